spike_event_encoder: RTL and testbench

Downstream stage of `lif_neuron_network`. It consumes the per-neuron spike lines (`spike_output`, `spike_1`, `spike_2`, `spike_3`) and converts rising edges into timestamped events. Events are buffered in a small FIFO and drained over a valid/ready interface. The block sits between the network and the tile output logic, so bursts of spikes can be read out without loss up to FIFO depth.

---
 rtl/spike_event_encoder.sv | 104 ++++++++++
 tb/tb_spike_event_encoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_encoder.sv
// spike_event_encoder: turns rising edges on spike lines into timestamped
// events and buffers them in a first-word-fall-through FIFO.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - synchronous active-high reset
//   spike_in   - level spike lines (bit 0 = spike_output, 1..3 = spike_1..3)
//   enable     - 1 = timestamp counts and events are captured
//   clear_ovf  - clears the sticky overflow flag
//   evt_ready  - consumer accepts the head event
//   evt_valid  - FIFO not empty
//   evt_data   - head event {timestamp, mask}
//   fifo_count - occupancy 0..DEPTH
//   overflow   - sticky, set when an event is dropped
module spike_event_encoder #(
    parameter int N_CH  = 4,
    parameter int TS_W  = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          spike_in,
    input  logic                     enable,
    input  logic                     clear_ovf,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [TS_W+N_CH-1:0]     evt_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TS_W + N_CH;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [TS_W-1:0] r_ts;
    logic [N_CH-1:0] r_spike_prev;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_ovf;

    logic [N_CH-1:0] w_rise;
    logic            w_event;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    assign w_rise  = spike_in & ~r_spike_prev;
    assign w_event = enable & (|w_rise);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = (r_count != '0) & evt_ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts         <= '0;
            r_spike_prev <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_spike_prev <= spike_in;
            if (enable) begin
                r_ts <= r_ts + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage needs no reset; entries are only visible when counted.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= {r_ts, w_rise};
        end
    end

    assign evt_valid  = (r_count != '0);
    assign evt_data   = evt_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Testbench for spike_event_encoder: queue-based reference model with a
// per-cycle compare process plus directed literal checks.
module tb_spike_event_encoder;

    localparam int N_CH  = 4;
    localparam int TS_W  = 8;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      spike_in;
    logic            enable;
    logic            clear_ovf;
    logic            evt_ready;
    logic            evt_valid;
    logic [11:0]     evt_data;
    logic [3:0]      fifo_count;
    logic            overflow;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    logic [11:0] m_q[$];
    int          m_ts;
    logic [3:0]  m_prev;
    logic        m_ovf;

    spike_event_encoder #(.N_CH(N_CH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .spike_in(spike_in), .enable(enable),
        .clear_ovf(clear_ovf), .evt_ready(evt_ready),
        .evt_valid(evt_valid), .evt_data(evt_data),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: events as a queue, timestamp as a plain counter.
    always @(posedge clk) begin
        logic [3:0] rise;
        if (reset) begin
            m_q.delete();
            m_ts = 0;
            m_prev = '0;
            m_ovf = 1'b0;
        end else begin
            rise = spike_in & ~m_prev;
            if (m_q.size() != 0 && evt_ready) void'(m_q.pop_front());
            if (enable && rise != 0) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_ts[7:0], rise});
                else m_ovf = 1'b1;
            end else if (clear_ovf) begin
                m_ovf = 1'b0;
            end
            if (enable) m_ts = (m_ts + 1) % 256;
            m_prev = spike_in;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("count", 32'(fifo_count), 32'(m_q.size()));
            check("valid", 32'(evt_valid), 32'(m_q.size() != 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (m_q.size() != 0) check("data", 32'(evt_data), 32'(m_q[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int saved_ts;

    initial begin
        reset = 1'b1; spike_in = '0; enable = 1'b0;
        clear_ovf = 1'b0; evt_ready = 1'b0;
        tick();
        started = 1;
        tick();
        reset = 1'b0;
        check("rst_count", 32'(fifo_count), 0);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_data", 32'(evt_data), 0);

        // single event at ts=5
        enable = 1'b1;
        repeat (5) tick();
        spike_in = 4'b0001;
        tick();
        check("ev1_data", 32'(evt_data), 32'h051);
        check("ev1_count", 32'(fifo_count), 1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("ev1_popped", 32'(evt_valid), 0);

        // coincident edges at ts=20, then held high
        spike_in = 4'b0000;
        repeat (13) tick();
        spike_in = 4'b1010;
        tick();
        check("ev2_data", 32'(evt_data), 32'h14A);
        repeat (10) tick();
        check("ev2_hold_count", 32'(fifo_count), 1);
        spike_in = 4'b0000;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;

        // overflow on the 9th edge
        for (int i = 0; i < 9; i++) begin
            spike_in = 4'(1 << (i % 4));
            tick();
            spike_in = 4'b0000;
            tick();
        end
        check("ovf_count", 32'(fifo_count), 8);
        check("ovf_flag", 32'(overflow), 1);
        evt_ready = 1'b1;
        repeat (8) tick();
        evt_ready = 1'b0;
        check("drain_count", 32'(fifo_count), 0);
        check("ovf_sticky", 32'(overflow), 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) begin
            spike_in = 4'b0100;
            tick();
            spike_in = 4'b0000;
            tick();
        end
        check("full_count", 32'(fifo_count), 8);
        spike_in = 4'b1000;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("fullpop_count", 32'(fifo_count), 8);
        check("fullpop_ovf", 32'(overflow), 0);
        check("fullpop_tail", 32'(m_q[7][3:0]), 32'h8);
        spike_in = 4'b0000;
        evt_ready = 1'b1;
        repeat (8) tick();
        evt_ready = 1'b0;

        // timestamp wrap 255 -> 0
        for (int i = 0; i < 300 && m_ts != 255; i++) tick();
        check("wrap_reached", 32'(m_ts), 255);
        spike_in = 4'b0001;
        tick();
        spike_in = 4'b0011;
        tick();
        check("wrap_count", 32'(fifo_count), 2);
        check("wrap_ts255", 32'(evt_data), 32'hFF1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("wrap_ts0", 32'(evt_data), 32'h002);
        evt_ready = 1'b1;
        spike_in = 4'b0000;
        tick();
        evt_ready = 1'b0;

        // disabled: edges ignored, ts frozen
        saved_ts = m_ts;
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            spike_in = 4'(i[0] ? 4'b1111 : 4'b0000);
            tick();
        end
        check("dis_count", 32'(fifo_count), 0);
        spike_in = 4'b0000;
        tick();
        enable = 1'b1;
        spike_in = 4'b0010;
        tick();
        check("dis_ts_frozen", 32'(evt_data), 32'({saved_ts[7:0], 4'b0010}));

        // three entries then mid-run reset with a line held high
        for (int i = 0; i < 2; i++) begin
            spike_in = 4'b0000;
            tick();
            spike_in = 4'b0001;
            tick();
        end
        check("pre_rst_count", 32'(fifo_count), 3);
        spike_in = 4'b0100;
        reset = 1'b1;
        evt_ready = 1'b1;
        tick();
        reset = 1'b0;
        evt_ready = 1'b0;
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_valid", 32'(evt_valid), 0);
        tick();
        check("post_rst_data", 32'(evt_data), 32'h004);
        check("post_rst_count", 32'(fifo_count), 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
